prod_accum: RTL
===============

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 The block SHALL have parameter ACC_W, default 11, giving the accumulator width in bits (legal range 8..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: requests a new accumulation run; sampled only in IDLE.
REQ-005 The block SHALL have port count, input, 3 bits: number of products in the run, sampled with start; value 0 means 8.
REQ-006 The block SHALL have port prod_in, input, 8 bits: unsigned product from the upstream 4x4 array multiplier.
REQ-007 The block SHALL have port prod_valid, input, 1 bit: prod_in holds a valid product.
REQ-008 The block SHALL have port prod_ready, output, 1 bit: the block accepts prod_in this cycle.
REQ-009 The block SHALL have port acc_out, output, ACC_W bits: accumulated sum.
REQ-010 The block SHALL have port acc_valid, output, 1 bit: acc_out holds a finished result.
REQ-011 The block SHALL have port acc_ready, input, 1 bit: the downstream stage consumes the result.
REQ-012 The block SHALL have port ovf, output, 1 bit: a carry out of acc_out occurred during the current run.
REQ-013 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-015 All outputs SHALL be driven from registers or decoded from the state only, with no combinational path from any input to any output.
REQ-016 In IDLE with start=1, the next edge SHALL clear acc_out and ovf, load the remaining-count register (0 loads 8), and enter ACCUM.
REQ-017 In IDLE with start=0, the block SHALL stay in IDLE and hold acc_out.
REQ-018 prod_ready SHALL be 1 exactly when the state is ACCUM.
REQ-019 A transfer SHALL occur on an edge where prod_valid=1 and prod_ready=1; on each transfer, acc_out SHALL take (acc_out + zero-extended prod_in) mod 2^ACC_W and remaining SHALL decrement by 1.
REQ-020 A cycle with prod_valid=0 in ACCUM SHALL leave acc_out, remaining and the state unchanged (stall, no timeout).
REQ-021 ovf SHALL be sticky: it is set on any transfer whose addition carries out of bit ACC_W-1, and it is cleared only at start or reset.
REQ-022 A transfer with remaining=1 SHALL move the FSM to DONE on the same edge, so acc_valid=1 in the cycle immediately after the last transfer.
REQ-023 In DONE, acc_valid SHALL be 1 and acc_out and ovf SHALL be held stable until acc_ready=1.
REQ-024 In DONE with acc_ready=1, the FSM SHALL return to IDLE on that edge, and acc_out SHALL keep its last value.
REQ-025 start SHALL be ignored in ACCUM and in DONE, including in the DONE cycle where acc_ready=1; no run is queued.
REQ-026 prod_in SHALL be ignored whenever prod_ready=0.
REQ-027 With the default ACC_W=11, a run of 8 products of 225 SHALL give 1800 with ovf=0.
REQ-028 Minimum run latency SHALL be start edge, then count transfer cycles, then 1 cycle to acc_valid (count+1 cycles after start for back-to-back valid products).

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for clk, force: state=IDLE, acc_out=0, remaining=0, ovf=0, acc_valid=0, prod_ready=0, busy=0.
REQ-030 Reset asserted mid-run (in ACCUM or DONE) SHALL discard the partial sum, and no result SHALL be presented afterward.
REQ-031 After reset deasserts, the first edge SHALL be able to accept start.

Verification
REQ-032 count=3, prod_in 15, 30, 225 back-to-back -> acc_valid rises 4 cycles after start, acc_out=270, ovf=0.
REQ-033 count=0, eight products of 225 with acc_ready=1 -> acc_out=1800, ovf=0, acc_valid high for exactly one cycle, then IDLE.
REQ-034 ACC_W=8, count=2, products 200 and 100 -> acc_out=44, ovf=1.
REQ-035 count=2 with prod_valid low for 3 cycles between products, and acc_ready held 0 for 5 cycles in DONE -> acc_out stable and acc_valid held throughout, and start pulses in ACCUM/DONE cause no new run.
REQ-036 reset asserted between clock edges after the 2nd of 4 transfers -> all outputs 0 at once, and a following run of count=1 with product 9 gives acc_out=9.

Source files
------------

// File: rtl/prod_accum.sv
// Accumulates a run of 1..8 unsigned 8-bit products from the upstream multiplier.
// The finished sum is held with a sticky carry-out flag until downstream takes it.
//
// state | meaning
// IDLE  | waiting for start; acc_out holds the last result
// ACCUM | prod_ready high; adds each valid product and counts remaining down
// DONE  | acc_valid high; result and ovf are held until acc_ready
module prod_accum #(
  parameter int ACC_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       count,
  input  logic [7:0]       prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] remaining;
  logic [ACC_W:0] sum_ext;

  // Top bit of sum_ext is the carry out of acc_out.
  always_comb begin
    sum_ext = {1'b0, acc_out} + {{(ACC_W-7){1'b0}}, prod_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc_out    <= '0;
      remaining  <= 4'd0;
      ovf        <= 1'b0;
      acc_valid  <= 1'b0;
      prod_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out    <= '0;
            ovf        <= 1'b0;
            remaining  <= (count == 3'd0) ? 4'd8 : {1'b0, count};
            state      <= ACCUM;
            prod_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_out   <= sum_ext[ACC_W-1:0];
            remaining <= remaining - 4'd1;
            if (sum_ext[ACC_W]) begin
              ovf <= 1'b1;
            end
            if (remaining == 4'd1) begin
              state      <= DONE;
              prod_ready <= 1'b0;
              acc_valid  <= 1'b1;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here, so no run gets queued.
          if (acc_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          acc_valid  <= 1'b0;
          prod_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
